// File: rtl/accum_sched.sv
// Round-robin two-client scheduler that sequences clear/load/accumulate for the
// shared accumulator, returning the sum with sticky carry/overflow and a done pulse.
module accum_sched #(
  parameter int W     = 8,
  parameter int LEN_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req,
  input  logic [LEN_W-1:0] i_len0,
  input  logic [LEN_W-1:0] i_len1,
  input  logic [W-1:0]     i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [1:0]       o_gnt,
  output logic             o_busy,
  output logic [W-1:0]     o_sum,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_done,
  output logic             o_done_id
);

  typedef enum logic [1:0] {IDLE, LOAD, ACC, DONE} state_t;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } acc_t;

  state_t           state, state_n;
  acc_t             acc;
  logic             ptr, gnt_idx, win, accept, ovf_add;
  logic [LEN_W-1:0] cnt, len_sel;
  logic [W:0]       add;

  // Tie goes to the client that was not served last.
  always_comb begin
    win = ~ptr;
    case (i_req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = ~ptr;
    endcase
  end

  assign len_sel = gnt_idx ? i_len1 : i_len0;
  assign accept  = (state == ACC) & i_valid;
  assign add     = {1'b0, acc.sum} + {1'b0, i_data};
  assign ovf_add = (acc.sum[W-1] == i_data[W-1]) & (add[W-1] != acc.sum[W-1]);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|i_req) state_n = LOAD;
      LOAD:    state_n = (len_sel == '0) ? DONE : ACC;
      ACC:     if (accept && cnt == LEN_W'(1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      ptr     <= 1'b1;
      gnt_idx <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (|i_req) begin
          gnt_idx <= win;
          ptr     <= win;
        end
        LOAD: begin
          cnt <= len_sel;
          acc <= '0;
        end
        ACC: if (accept) begin
          acc.sum   <= add[W-1:0];
          acc.carry <= acc.carry | add[W];
          acc.ovf   <= acc.ovf | ovf_add;
          cnt       <= cnt - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Control outputs decode from state only, so reset clears them with the state.
  assign o_busy    = (state != IDLE);
  assign o_ready   = (state == ACC);
  assign o_done    = (state == DONE);
  assign o_done_id = o_done & gnt_idx;
  assign o_gnt     = o_busy ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  assign o_sum     = acc.sum;
  assign o_carry   = acc.carry;
  assign o_ovf     = acc.ovf;

endmodule

// File: tb/tb_accum_sched.sv
// Directed bench for accum_sched: expected job results are queued when a job is
// launched and compared when the done pulse appears.
module tb_accum_sched;

  logic       i_clk = 1'b0, i_rst = 1'b1;
  logic [1:0] i_req = '0;
  logic [3:0] i_len0 = '0, i_len1 = '0;
  logic [7:0] i_data = '0;
  logic       i_valid = 1'b0;
  logic       o_ready, o_busy, o_carry, o_ovf, o_done, o_done_id;
  logic [1:0] o_gnt;
  logic [7:0] o_sum;

  accum_sched #(.W(8), .LEN_W(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_len0(i_len0), .i_len1(i_len1),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready), .o_gnt(o_gnt),
    .o_busy(o_busy), .o_sum(o_sum), .o_carry(o_carry), .o_ovf(o_ovf),
    .o_done(o_done), .o_done_id(o_done_id)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] sum;
    logic       c;
    logic       v;
    logic       id;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ops[17];
  int         checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sum"},   o_sum,     0);
    check({tag, "_carry"}, o_carry,   0);
    check({tag, "_ovf"},   o_ovf,     0);
    check({tag, "_gnt"},   o_gnt,     0);
    check({tag, "_ready"}, o_ready,   0);
    check({tag, "_busy"},  o_busy,    0);
    check({tag, "_done"},  o_done,    0);
    check({tag, "_id"},    o_done_id, 0);
  endtask

  // Called at #1 after an edge in an IDLE cycle; the next edge is the request edge E0.
  // gap_k: insert one invalid ACC cycle before operand gap_k (-1 = none).
  // drop_cyc: cycles after E0 at which all requests are released (large = hold).
  task automatic do_job(input int c, input int len, input int gap_k, input int drop_cyc);
    exp_t e;
    int   s_u, s_s, k, cyc;
    logic rdy, gapped, got;
    e.sum = '0; e.c = 1'b0; e.v = 1'b0; e.id = c[0];
    for (int j = 0; j < len; j++) begin
      s_u = int'(e.sum) + int'(ops[j]);
      s_s = int'($signed(e.sum)) + int'($signed(ops[j]));
      if (s_u > 255) e.c = 1'b1;
      if (s_s > 127 || s_s < -128) e.v = 1'b1;
      e.sum = s_u[7:0];
    end
    e.lat = (len == 0) ? 1 : len + 1 + ((gap_k >= 0 && gap_k < len) ? 1 : 0);
    sb.push_back(e);

    i_req[c] = 1'b1;
    if (c == 0) i_len0 = len[3:0]; else i_len1 = len[3:0];
    @(posedge i_clk); #1;
    check("gnt_load", o_gnt, (c == 0) ? 2'b01 : 2'b10);
    check("busy_load", o_busy, 1);
    check("ready_load", o_ready, 0);

    cyc = 0; k = 0; gapped = 1'b0; got = 1'b0;
    while (!got && cyc < 40) begin
      if (cyc == drop_cyc) i_req = '0;
      rdy = o_ready;
      if (rdy && k == gap_k && !gapped) begin
        i_valid = 1'b0;
        gapped  = 1'b1;
      end else begin
        i_valid = (k < len);
      end
      i_data = ops[k];
      @(posedge i_clk);
      cyc++;
      if (rdy && i_valid) k++;
      #1;
      got = o_done;
    end
    i_valid = 1'b0;

    e = sb.pop_front();
    check("done_seen", got, 1);
    check("latency", cyc, e.lat);
    check("sum", o_sum, e.sum);
    check("carry", o_carry, e.c);
    check("ovf", o_ovf, e.v);
    check("done_id", o_done_id, e.id);
    check("gnt_done", o_gnt, (c == 0) ? 2'b01 : 2'b10);

    @(posedge i_clk); #1;
    check("idle_busy", o_busy, 0);
    check("done_pulse", o_done, 0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Basic job, client 0.
    ops[0] = 8'd10; ops[1] = 8'd20; ops[2] = 8'd30;
    do_job(0, 3, -1, 0);

    // Signed overflow, then flags cleared by the next job's load.
    ops[0] = 8'h64; ops[1] = 8'h64;
    do_job(1, 2, -1, 0);
    ops[0] = 8'hFF; ops[1] = 8'h02;
    do_job(1, 2, -1, 0);

    // Both requesting continuously: grants alternate starting with client 0.
    ops[0] = 8'h11;
    i_len0 = 4'd1; i_len1 = 4'd1;
    i_req  = 2'b11;
    do_job(0, 1, -1, 99);
    do_job(1, 1, -1, 99);
    do_job(0, 1, -1, 99);
    do_job(1, 1, -1, 99);
    i_req = '0;
    @(posedge i_clk); #1;

    // Zero length and a gap inside the stream.
    do_job(0, 0, -1, 0);
    ops[0] = 8'h80; ops[1] = 8'h80;
    do_job(1, 2, 1, 0);

    // Longer job with pseudo-random operands.
    for (int j = 0; j < 7; j++) ops[j] = 8'($urandom_range(0, 255));
    do_job(0, 7, 3, 0);

    // Reset in the middle of accumulation.
    i_req = 2'b01; i_len0 = 4'd3; i_valid = 1'b1; i_data = 8'd5;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    check("mid_sum", o_sum, 8'd5);
    check("mid_ready", o_ready, 1);
    #3 i_rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    i_req = '0; i_valid = 1'b0;
    @(posedge i_clk);
    #4 i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("post_rst_busy", o_busy, 0);
    ops[0] = 8'd7; ops[1] = 8'd9;
    do_job(1, 2, -1, 0);
    i_req = 2'b11;
    ops[0] = 8'd3;
    do_job(0, 1, -1, 0);

    // Client drops its request while in ACC; job still completes.
    ops[0] = 8'd1; ops[1] = 8'd2; ops[2] = 8'd3;
    do_job(0, 3, -1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
